freq_gate_ctrl: RTL and testbench

//  Measurement sequencer for the freq_measure counter block.
//  - Generates freq_measure's gate window, waits for the count to settle, latches it,
//    and scales it to Hz.
//  - Gate time is selectable (10 ms / 100 ms / 1 s) or auto-ranged; single-shot or continuous.
//  - Sits between the top-level controls and freq_measure.

---
 rtl/freq_gate_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// freq_gate_ctrl
//   Measurement sequencer for the freq_measure counter block. It opens a gate
//   window of a selectable length (10 ms / 100 ms / 1 s, or auto-ranged),
//   waits for the edge count to settle, latches it, and scales it to Hz.
//   Measurements run single-shot on a start pulse, or back to back while
//   continuous is high.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE
//   (busy=0); a start seen while busy=1 is dropped. freq_valid is a one-cycle
//   strobe with no back-pressure: freq_hz/overrange are valid in that cycle
//   and hold until the next strobe.
//
// Ports
//   clk_100kHz  in   1   system clock, rising edge
//   rst         in   1   synchronous reset, active-high
//   start       in   1   begin one measurement (ignored while busy)
//   continuous  in   1   re-arm automatically after each result
//   auto_range  in   1   gate chosen by auto-ranging; gate_sel ignored
//   gate_sel    in   2   0 = 10 ms, 1 = 100 ms, 2/3 = 1 s
//   freq_cnt    in   32  edge count from freq_measure
//   gate        out  1   gate window to freq_measure
//   busy        out  1   high in every state except IDLE
//   freq_hz     out  32  last scaled result (Hz)
//   freq_valid  out  1   one-cycle strobe when freq_hz updates
//   overrange   out  1   last result saturated to 32'hFFFF_FFFF
//   range_cur   out  2   gate range of the current/last measurement
//   state_dbg   out  3   current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module freq_gate_ctrl #(
  parameter int unsigned CLK_HZ        = 100000,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned AUTO_LO       = 100,
  parameter int unsigned AUTO_HI       = 60000
) (
  input  logic        clk_100kHz,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        auto_range,
  input  logic [1:0]  gate_sel,
  input  logic [31:0] freq_cnt,
  output logic        gate,
  output logic        busy,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        overrange,
  output logic [1:0]  range_cur,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_SCALE  = 3'd4
  } state_t;

  localparam logic [31:0] LEN0_M1   = 32'(CLK_HZ / 100 - 1);
  localparam logic [31:0] LEN1_M1   = 32'(CLK_HZ / 10 - 1);
  localparam logic [31:0] LEN2_M1   = 32'(CLK_HZ - 1);
  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LO_TH     = 32'(AUTO_LO);
  localparam logic [31:0] HI_TH     = 32'(AUTO_HI);

  state_t      state;
  logic [31:0] gate_cnt;
  logic [3:0]  settle_cnt;
  logic [31:0] cnt_lat;

  logic [1:0]  sel_range;
  logic [1:0]  arm_range;
  logic [31:0] arm_len_m1;
  logic [35:0] cnt36;
  logic [35:0] prod;
  logic        ovf;
  logic [1:0]  next_auto;

  assign state_dbg = state;

  always_comb begin
    // gate_sel 3 is an alias of the 1 s range
    sel_range  = (gate_sel == 2'd3) ? 2'd2 : gate_sel;
    // auto mode keeps whatever range the previous result chose
    arm_range  = auto_range ? range_cur : sel_range;
    arm_len_m1 = LEN2_M1;
    case (arm_range)
      2'd0:    arm_len_m1 = LEN0_M1;
      2'd1:    arm_len_m1 = LEN1_M1;
      default: arm_len_m1 = LEN2_M1;
    endcase
  end

  // Scaling by shift-and-add; a 36-bit result with any of bits 35:32 set
  // does not fit freq_hz and is saturated.
  always_comb begin
    cnt36 = {4'd0, cnt_lat};
    prod  = cnt36;
    case (range_cur)
      2'd0:    prod = (cnt36 << 6) + (cnt36 << 5) + (cnt36 << 2);
      2'd1:    prod = (cnt36 << 3) + (cnt36 << 1);
      default: prod = cnt36;
    endcase
    ovf = |prod[35:32];
  end

  // Auto-range step: low counts lengthen the gate, high counts shorten it,
  // clamped at both ends.
  always_comb begin
    next_auto = range_cur;
    if (cnt_lat < LO_TH && range_cur < 2'd2)
      next_auto = range_cur + 2'd1;
    else if (cnt_lat > HI_TH && range_cur > 2'd0)
      next_auto = range_cur - 2'd1;
  end

  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      state      <= S_IDLE;
      gate       <= 1'b0;
      busy       <= 1'b0;
      freq_hz    <= 32'd0;
      freq_valid <= 1'b0;
      overrange  <= 1'b0;
      range_cur  <= 2'd2;
      gate_cnt   <= 32'd0;
      settle_cnt <= 4'd0;
      cnt_lat    <= 32'd0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || continuous) begin
            state <= S_ARM;
            busy  <= 1'b1;
          end
        end
        S_ARM: begin
          range_cur <= arm_range;
          gate_cnt  <= arm_len_m1;
          gate      <= 1'b1;
          state     <= S_GATE;
        end
        S_GATE: begin
          // counter runs len-1 .. 0, so the gate is high for exactly len cycles
          if (gate_cnt == 32'd0) begin
            gate       <= 1'b0;
            settle_cnt <= SETTLE_M1;
            state      <= S_SETTLE;
          end else begin
            gate_cnt <= gate_cnt - 32'd1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            cnt_lat <= freq_cnt;
            state   <= S_SCALE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_SCALE: begin
          freq_hz    <= ovf ? 32'hFFFF_FFFF : prod[31:0];
          overrange  <= ovf;
          freq_valid <= 1'b1;
          if (auto_range)
            range_cur <= next_auto;
          if (continuous) begin
            state <= S_ARM;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          gate  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_ctrl
//   Bench for freq_gate_ctrl with a scaled-down clock rate (CLK_HZ=1000, so
//   gates are 10 / 100 / 1000 cycles). A fixed table of measurements with
//   hand-computed results, randomized measurements against a reference
//   model, and hand-written sequences for continuous mode, auto-ranging,
//   restart-while-busy and reset in the middle of a gate.
// ---------------------------------------------------------------------------
module tb_freq_gate_ctrl;

  localparam int CLK_HZ = 1000;
  localparam int SETTLE = 4;
  localparam int BUDGET = 2000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        continuous;
  logic        auto_range;
  logic [1:0]  gate_sel;
  logic [31:0] freq_cnt;
  logic        gate;
  logic        busy;
  logic [31:0] freq_hz;
  logic        freq_valid;
  logic        overrange;
  logic [1:0]  range_cur;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic        ovr_q[$];

  freq_gate_ctrl #(
    .CLK_HZ(CLK_HZ), .SETTLE_CYCLES(SETTLE), .AUTO_LO(100), .AUTO_HI(60000)
  ) dut (
    .clk_100kHz(clk), .rst(rst), .start(start), .continuous(continuous),
    .auto_range(auto_range), .gate_sel(gate_sel), .freq_cnt(freq_cnt),
    .gate(gate), .busy(busy), .freq_hz(freq_hz), .freq_valid(freq_valid),
    .overrange(overrange), .range_cur(range_cur), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [1:0] model_range(input logic [1:0] sel);
    return (sel >= 2'd2) ? 2'd2 : sel;
  endfunction

  function automatic int model_len(input logic [1:0] rng);
    if (rng == 2'd0) return CLK_HZ / 100;
    if (rng == 2'd1) return CLK_HZ / 10;
    return CLK_HZ;
  endfunction

  // bit 32 = overrange, bits 31:0 = Hz
  function automatic logic [32:0] model_hz(input logic [1:0] rng, input logic [31:0] cnt);
    longint unsigned p;
    longint unsigned mult;
    mult = (rng == 2'd0) ? 100 : (rng == 2'd1) ? 10 : 1;
    p = longint'(cnt) * mult;
    if (p > 64'h0000_0000_FFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, p[31:0]};
  endfunction

  // scoreboard: every freq_valid must match the oldest expected result
  always @(negedge clk) begin
    if (freq_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_valid: got freq_valid=1 with freq_hz=%0h, expected no strobe", freq_hz);
      end else begin
        check("freq_hz", {32'd0, freq_hz}, {32'd0, exp_q.pop_front()});
        check("overrange", {63'd0, overrange}, {63'd0, ovr_q.pop_front()});
      end
    end
  end

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!freq_valid && cycles < BUDGET);
    if (!freq_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL valid_timeout: got no freq_valid in %0d cycles, expected one", cycles);
    end
  endtask

  // one single-shot measurement with timing checks
  task automatic run_meas(input logic [1:0] sel, input logic [31:0] cnt,
                          input logic [31:0] ehz, input logic eovr,
                          input int en, input logic [1:0] erng,
                          input int restart_at, input bit scramble);
    int k, rise, fall, vat, vcnt;
    gate_sel = sel;
    freq_cnt = cnt;
    exp_q.push_back(ehz);
    ovr_q.push_back(eovr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; rise = -1; fall = -1; vat = -1; vcnt = 0;
    while (k < BUDGET) begin
      if (gate && rise < 0) rise = k;
      if (!gate && rise >= 0 && fall < 0) fall = k;
      if (freq_valid) begin
        vcnt++;
        if (vat < 0) vat = k;
      end
      if (vat >= 0 && !busy) break;
      start = (k == restart_at);
      if (scramble && k == 3) gate_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("gate_rise", 64'(rise), 64'(2));
    check("gate_len", 64'(fall - rise), 64'(en));
    check("valid_lat", 64'(vat), 64'(2 + en + SETTLE + 1));
    check("valid_count", 64'(vcnt), 64'(1));
    check("busy_end", {63'd0, busy}, 64'd0);
    check("range_cur", {62'd0, range_cur}, {62'd0, erng});
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] cnt;
    logic [31:0] hz;
    logic        ovr;
    int          n;
    logic [1:0]  rng;
  } vec_t;

  vec_t tbl[12];

  initial begin : main
    int cyc;
    int w;
    logic [1:0]  rs;
    logic [31:0] rc;
    logic [32:0] m;

    tbl[0]  = '{2'd0, 32'd50,         32'd5000,       1'b0, 10,   2'd0};
    tbl[1]  = '{2'd1, 32'd123,        32'd1230,       1'b0, 100,  2'd1};
    tbl[2]  = '{2'd0, 32'h0300_0000,  32'hFFFF_FFFF,  1'b1, 10,   2'd0};
    tbl[3]  = '{2'd0, 32'd1,          32'd100,        1'b0, 10,   2'd0};
    tbl[4]  = '{2'd2, 32'd7,          32'd7,          1'b0, 1000, 2'd2};
    tbl[5]  = '{2'd3, 32'd999,        32'd999,        1'b0, 1000, 2'd2};
    tbl[6]  = '{2'd0, 32'd0,          32'd0,          1'b0, 10,   2'd0};
    tbl[7]  = '{2'd0, 32'd42949672,   32'd4294967200, 1'b0, 10,   2'd0};
    tbl[8]  = '{2'd0, 32'd42949673,   32'hFFFF_FFFF,  1'b1, 10,   2'd0};
    tbl[9]  = '{2'd1, 32'd429496729,  32'd4294967290, 1'b0, 100,  2'd1};
    tbl[10] = '{2'd1, 32'd429496730,  32'hFFFF_FFFF,  1'b1, 100,  2'd1};
    tbl[11] = '{2'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1000, 2'd2};

    rst = 1'b1; start = 1'b0; continuous = 1'b0; auto_range = 1'b0;
    gate_sel = 2'd0; freq_cnt = 32'd0;
    do_reset();

    // reset state
    check("rst_gate", {63'd0, gate}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_freq_hz", {32'd0, freq_hz}, 64'd0);
    check("rst_valid", {63'd0, freq_valid}, 64'd0);
    check("rst_overrange", {63'd0, overrange}, 64'd0);
    check("rst_range", {62'd0, range_cur}, 64'd2);

    // fixed table
    for (int i = 0; i < 12; i++)
      run_meas(tbl[i].sel, tbl[i].cnt, tbl[i].hz, tbl[i].ovr, tbl[i].n, tbl[i].rng, 0, 1'b0);

    // second start in the middle of a gate is ignored
    run_meas(2'd1, 32'd77, 32'd770, 1'b0, 100, 2'd1, 40, 1'b0);

    // randomized measurements, gate_sel disturbed mid-measurement
    for (int i = 0; i < 16; i++) begin
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       rc = 32'($urandom_range(0, 1000));
        1:       rc = 32'($urandom_range(40000000, 50000000));
        default: rc = $urandom & 32'h1FFF_FFFF;
      endcase
      m = model_hz(model_range(rs), rc);
      run_meas(rs, rc, m[31:0], m[32], model_len(model_range(rs)),
               model_range(rs), 0, ($urandom_range(0, 1) == 1));
    end

    // continuous mode: steady period, then drop continuous mid-gate
    gate_sel = 2'd0;
    freq_cnt = 32'd3;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'd300);
      ovr_q.push_back(1'b0);
    end
    continuous = 1'b1;
    wait_valid(cyc);
    for (int i = 0; i < 3; i++) begin
      wait_valid(cyc);
      check("cont_period", 64'(cyc), 64'(10 + SETTLE + 2));
    end
    w = 0;
    while (!gate && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    check("cont_gate_seen", {63'd0, gate}, 64'd1);
    repeat (3) @(negedge clk);
    continuous = 1'b0;
    wait_valid(cyc);
    check("cont_last_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("cont_idle_busy", {63'd0, busy}, 64'd0);
    check("cont_idle_gate", {63'd0, gate}, 64'd0);
    check("cont_queue_empty", 64'(exp_q.size()), 64'd0);

    // reset halfway through a 1 s gate
    gate_sel = 2'd2;
    freq_cnt = 32'd55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    check("pre_rst_gate", {63'd0, gate}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_gate", {63'd0, gate}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_freq_hz", {32'd0, freq_hz}, 64'd0);
    check("mid_rst_valid", {63'd0, freq_valid}, 64'd0);
    check("mid_rst_range", {62'd0, range_cur}, 64'd2);
    rst = 1'b0;
    repeat (1100) @(negedge clk);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    // auto-ranging: low count holds at 1 s, high count walks down without wrap
    auto_range = 1'b1;
    gate_sel = 2'd0;
    freq_cnt = 32'd10;
    exp_q.push_back(32'd10); ovr_q.push_back(1'b0);
    continuous = 1'b1;
    wait_valid(cyc);
    check("auto_range_a", {62'd0, range_cur}, 64'd2);
    exp_q.push_back(32'd10); ovr_q.push_back(1'b0);
    wait_valid(cyc);
    check("auto_range_b", {62'd0, range_cur}, 64'd2);
    freq_cnt = 32'd70000;
    exp_q.push_back(32'd70000); ovr_q.push_back(1'b0);
    wait_valid(cyc);
    check("auto_period_2", 64'(cyc), 64'(1000 + SETTLE + 2));
    check("auto_range_c", {62'd0, range_cur}, 64'd1);
    exp_q.push_back(32'd700000); ovr_q.push_back(1'b0);
    wait_valid(cyc);
    check("auto_period_1", 64'(cyc), 64'(100 + SETTLE + 2));
    check("auto_range_d", {62'd0, range_cur}, 64'd0);
    exp_q.push_back(32'd7000000); ovr_q.push_back(1'b0);
    wait_valid(cyc);
    check("auto_period_0", 64'(cyc), 64'(10 + SETTLE + 2));
    check("auto_range_e", {62'd0, range_cur}, 64'd0);
    exp_q.push_back(32'd7000000); ovr_q.push_back(1'b0);
    continuous = 1'b0;
    wait_valid(cyc);
    check("auto_range_f", {62'd0, range_cur}, 64'd0);
    repeat (20) @(negedge clk);
    check("auto_idle_busy", {63'd0, busy}, 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
